// File: rtl/sfx_sequencer.sv
// Sound-effect player: turns a one-cycle request into a timed note sequence
// and drives a square-wave tone output, with start/busy/done handshake and mute.
module sfx_sequencer #(
   parameter int CLK_HZ  = 50000000,
   parameter int TICK_HZ = 4,
   parameter int NOTE_W  = 20,
   parameter int DUR_W   = 5,
   parameter int PREEMPT = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        sound,
   input  logic              mute,
   output logic              busy,
   output logic              done,
   output logic              tone,
   output logic [NOTE_W-1:0] note,
   output logic [1:0]        step
);

   localparam int TICK_DIV  = CLK_HZ / TICK_HZ;
   localparam int CNT_W     = DUR_W + $clog2(TICK_DIV);
   localparam bit PREEMPT_EN = (PREEMPT != 0);

   localparam logic [NOTE_W-1:0] P_MOVE   = NOTE_W'(CLK_HZ / 459);
   localparam logic [NOTE_W-1:0] P_SWITCH = NOTE_W'(CLK_HZ / 980);
   localparam logic [NOTE_W-1:0] P_ENTER  = NOTE_W'(CLK_HZ / 700);
   localparam logic [NOTE_W-1:0] P_REST   = NOTE_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PLAY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   typedef struct packed {
      logic [NOTE_W-1:0] period;
      logic [DUR_W-1:0]  units;
      logic              last;
   } rom_entry_t;

   // Fixed sound table; out-of-range steps fall back to a final one-unit rest.
   function automatic rom_entry_t rom_lookup(input logic [1:0] snd, input logic [1:0] stp);
      rom_entry_t e;
      e.period = P_REST;
      e.units  = DUR_W'(1);
      e.last   = 1'b1;
      case (snd)
         2'd0: begin
            e.period = P_MOVE;
            e.units  = DUR_W'(2);
         end
         2'd1: begin
            e.period = P_SWITCH;
            e.units  = DUR_W'(8);
         end
         2'd2: begin
            case (stp)
               2'd0: begin
                  e.period = P_ENTER;
                  e.units  = DUR_W'(4);
                  e.last   = 1'b0;
               end
               2'd1: begin
                  e.period = P_REST;
                  e.units  = DUR_W'(1);
                  e.last   = 1'b0;
               end
               default: begin
                  e.period = P_SWITCH;
                  e.units  = DUR_W'(4);
               end
            endcase
         end
         default: begin
            e.period = P_REST;
            e.units  = DUR_W'(2);
         end
      endcase
      return e;
   endfunction

   // Down-counter load value: the step ends when the counter reaches zero.
   function automatic logic [CNT_W-1:0] dur_clocks(input logic [DUR_W-1:0] units);
      return CNT_W'(units) * CNT_W'(TICK_DIV) - CNT_W'(1);
   endfunction

   state_t            state_q, state_d;
   logic [1:0]        sound_q, sound_d;
   logic [1:0]        step_q, step_d;
   logic              last_q, last_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [NOTE_W-1:0] phase_q, phase_d;
   logic [NOTE_W-1:0] note_q, note_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              tone_q, tone_d;

   logic              load_s;
   logic [1:0]        load_sound_s;
   logic [1:0]        load_step_s;
   rom_entry_t        load_entry_s;

   // Next-state, step sequencing, tone phase and registered-output decode.
   always_comb begin
      state_d      = state_q;
      sound_d      = sound_q;
      step_d       = step_q;
      last_d       = last_q;
      cnt_d        = cnt_q;
      note_d       = note_q;
      phase_d      = '0;
      load_s       = 1'b0;
      load_sound_s = sound;
      load_step_s  = 2'd0;

      case (state_q)
         S_PLAY: begin
            if (PREEMPT_EN && start) begin
               load_s = 1'b1;
            end else if (cnt_q == '0) begin
               if (last_q) begin
                  state_d = S_DONE;
                  step_d  = 2'd0;
                  note_d  = '0;
               end else begin
                  load_s       = 1'b1;
                  load_sound_s = sound_q;
                  load_step_s  = step_q + 2'd1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            if (start) begin
               load_s = 1'b1;
            end else begin
               state_d = S_IDLE;
               step_d  = 2'd0;
               note_d  = '0;
            end
         end
      endcase

      load_entry_s = rom_lookup(load_sound_s, load_step_s);

      // A step load restarts the phase so every note begins on a high half.
      if (load_s) begin
         state_d = S_PLAY;
         sound_d = load_sound_s;
         step_d  = load_step_s;
         last_d  = load_entry_s.last;
         cnt_d   = dur_clocks(load_entry_s.units);
         note_d  = load_entry_s.period;
      end else if ((state_q == S_PLAY) && (state_d == S_PLAY)) begin
         phase_d = (phase_q == note_q - NOTE_W'(1)) ? '0 : phase_q + NOTE_W'(1);
      end else begin
         phase_d = '0;
      end

      busy_d = (state_d == S_PLAY);
      done_d = (state_d == S_DONE);
      tone_d = busy_d && !mute && (note_d >= NOTE_W'(2)) && (phase_d < (note_d >> 1));
   end

   // State and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         sound_q <= 2'd0;
         step_q  <= 2'd0;
         last_q  <= 1'b0;
         cnt_q   <= '0;
         phase_q <= '0;
         note_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tone_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sound_q <= sound_d;
         step_q  <= step_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         note_q  <= note_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         tone_q  <= tone_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign tone = tone_q;
   assign note = note_q;
   assign step = step_q;

endmodule

// File: tb/tb_sfx_sequencer.sv
// Randomized bench for sfx_sequencer: a non-preempting and a preempting
// instance checked cycle by cycle against a table-driven timeline model.
module tb_sfx_sequencer;

   localparam int CLK_HZ   = 100000;
   localparam int TICK_HZ  = 100;
   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int NOTE_W   = 20;
   localparam int DUR_W    = 5;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start_a = 1'b0;
   logic              start_b = 1'b0;
   logic [1:0]        sound = 2'd0;
   logic              mute = 1'b0;

   logic              busy_a, done_a, tone_a, busy_b, done_b, tone_b;
   logic [NOTE_W-1:0] note_a, note_b;
   logic [1:0]        step_a, step_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sfx_sequencer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NOTE_W(NOTE_W), .DUR_W(DUR_W), .PREEMPT(0)) dut_a (
      .clk(clk), .reset(reset), .start(start_a), .sound(sound), .mute(mute),
      .busy(busy_a), .done(done_a), .tone(tone_a), .note(note_a), .step(step_a));

   sfx_sequencer #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ), .NOTE_W(NOTE_W), .DUR_W(DUR_W), .PREEMPT(1)) dut_b (
      .clk(clk), .reset(reset), .start(start_b), .sound(sound), .mute(mute),
      .busy(busy_b), .done(done_b), .tone(tone_b), .note(note_b), .step(step_b));

   // Sound table as listed: steps, frequency-derived periods and durations.
   function automatic int n_steps(input int s);
      return (s == 2) ? 3 : 1;
   endfunction

   function automatic int st_period(input int s, input int i);
      case (s)
         0: return CLK_HZ / 459;
         1: return CLK_HZ / 980;
         2: return (i == 0) ? CLK_HZ / 700 : ((i == 1) ? 1 : CLK_HZ / 980);
         default: return 1;
      endcase
   endfunction

   function automatic int st_units(input int s, input int i);
      case (s)
         0: return 2;
         1: return 8;
         2: return (i == 1) ? 1 : 4;
         default: return 2;
      endcase
   endfunction

   function automatic int seq_len(input int s);
      int total = 0;
      for (int i = 0; i < n_steps(s); i++) total += st_units(s, i) * TICK_DIV;
      return total;
   endfunction

   // Expected {busy,done,note,step,tone} in cycle N+k after a start sampled at edge N.
   function automatic logic [24:0] expect_out(input int s, input int k, input bit m);
      int t, d, p, ph;
      bit tn;
      if (k > seq_len(s)) return {1'b0, 1'b1, 20'd0, 2'd0, 1'b0};
      t = k - 1;
      for (int i = 0; i < n_steps(s); i++) begin
         d = st_units(s, i) * TICK_DIV;
         if (t < d) begin
            p  = st_period(s, i);
            ph = t % p;
            tn = (p >= 2) && !m && (ph < p / 2);
            return {1'b1, 1'b0, 20'(p), 2'(i), tn};
         end
         t -= d;
      end
      return '0;
   endfunction

   function automatic logic [24:0] observe(input bit which);
      return which ? {busy_b, done_b, note_b, step_b, tone_b}
                   : {busy_a, done_a, note_a, step_a, tone_a};
   endfunction

   task automatic run_seq(input bit which, input int snd, input int next_snd,
                          input int stop_at, input bit mute_rand, input bit poke);
      int len;
      bit mute_eff;
      logic [24:0] got_v, exp_v;
      len = seq_len(snd);
      mute_eff = mute;
      sound = 2'(snd);
      if (which) start_b = 1'b1; else start_a = 1'b1;
      for (int k = 1; k <= len + 1; k++) begin
         @(negedge clk);
         start_a = 1'b0;
         start_b = 1'b0;
         got_v = observe(which);
         exp_v = expect_out(snd, k, mute_eff);
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL seq dut%0d sound%0d cycle N+%0d: got busy=%b done=%b note=%0d step=%0d tone=%b, expected busy=%b done=%b note=%0d step=%0d tone=%b",
                     which, snd, k, got_v[24], got_v[23], got_v[22:3], got_v[2:1], got_v[0],
                     exp_v[24], exp_v[23], exp_v[22:3], exp_v[2:1], exp_v[0]);
            break;
         end
         if (k == stop_at) begin
            if (next_snd >= 0) begin
               sound = 2'(next_snd);
               if (which) start_b = 1'b1; else start_a = 1'b1;
            end
            break;
         end
         if ((k == len + 1) && (next_snd >= 0)) begin
            sound = 2'(next_snd);
            if (which) start_b = 1'b1; else start_a = 1'b1;
         end
         // Stray requests mid-play must not disturb the non-preempting player.
         if (poke && (k < len) && ($urandom_range(0, 99) == 0)) begin
            sound   = 2'($urandom_range(0, 3));
            start_a = 1'b1;
         end
         if (mute_rand && ($urandom_range(0, 499) == 0)) mute = ~mute;
         mute_eff = mute;
      end
   endtask

   task automatic idle_cycles(input int n);
      logic [24:0] got_v;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         for (int w = 0; w < 2; w++) begin
            got_v = observe(w[0]);
            checks++;
            if (got_v !== 25'd0) begin
               errors++;
               $display("FAIL idle dut%0d cycle %0d: got %h, expected 0", w, k, got_v);
            end
         end
      end
   endtask

   task automatic test_reset();
      logic [24:0] got_v;
      #2 reset = 1'b1;
      #1;
      for (int w = 0; w < 2; w++) begin
         got_v = observe(w[0]);
         checks++;
         if (got_v !== 25'd0) begin
            errors++;
            $display("FAIL reset_async dut%0d: got %h, expected 0", w, got_v);
         end
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      idle_cycles(50);
   endtask

   task automatic test_single_sounds();
      run_seq(1'b0, 0, -1, 0, 1'b0, 1'b0);
      idle_cycles(7);
      run_seq(1'b0, 2, -1, 0, 1'b0, 1'b0);
      idle_cycles(3);
      run_seq(1'b0, 3, -1, 0, 1'b0, 1'b0);
      idle_cycles(3);
   endtask

   task automatic test_mute();
      mute = 1'b0;
      run_seq(1'b0, 1, -1, 0, 1'b1, 1'b0);
      mute = 1'b0;
      idle_cycles(4);
   endtask

   task automatic test_back_to_back();
      int r;
      r = int'($urandom_range(0, 3));
      run_seq(1'b0, 0, 3, 0, 1'b0, 1'b0);
      run_seq(1'b0, 3, r, 0, 1'b0, 1'b0);
      run_seq(1'b0, r, -1, 0, 1'b0, 1'b0);
      idle_cycles(5);
   endtask

   task automatic test_ignore_start();
      run_seq(1'b0, 1, -1, 0, 1'b0, 1'b1);
      idle_cycles(5);
   endtask

   task automatic test_preempt();
      int s1, s2;
      run_seq(1'b1, 1, 0, 500, 1'b0, 1'b0);
      run_seq(1'b1, 0, -1, 0, 1'b0, 1'b0);
      idle_cycles(20);
      s1 = int'($urandom_range(0, 3));
      s2 = int'($urandom_range(0, 3));
      run_seq(1'b1, s1, s2, int'($urandom_range(1, seq_len(s1) - 1)), 1'b0, 1'b0);
      run_seq(1'b1, s2, -1, 0, 1'b0, 1'b0);
      idle_cycles(5);
   endtask

   task automatic test_mid_reset();
      logic [24:0] got_v;
      run_seq(1'b0, 2, -1, 4000 + int'($urandom_range(1, 999)), 1'b0, 1'b0);
      #2 reset = 1'b1;
      #1;
      got_v = observe(1'b0);
      checks++;
      if (got_v !== 25'd0) begin
         errors++;
         $display("FAIL reset_mid: got %h, expected 0", got_v);
      end
      @(negedge clk);
      reset = 1'b0;
      idle_cycles(5);
      run_seq(1'b0, 0, -1, 0, 1'b0, 1'b0);
      idle_cycles(5);
   endtask

   task automatic test_random();
      for (int n = 0; n < 2; n++) begin
         mute = 1'($urandom_range(0, 1));
         run_seq(1'b0, int'($urandom_range(0, 3)), -1, 0, 1'b1, 1'b1);
         mute = 1'b0;
         idle_cycles(int'($urandom_range(2, 30)));
      end
   endtask

   initial begin
      test_reset();
      test_single_sounds();
      test_mute();
      test_back_to_back();
      test_ignore_start();
      test_preempt();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sfx_sequencer.md
# sfx_sequencer

Parametrised sound-effect player that turns a one-cycle request for one of four UI sounds into a timed sequence of notes and drives a square-wave `tone` output directly. It extends the single-note sound lookup with multi-step sequences, an internal tone generator and duration timer, a start/busy/done handshake, a mute control and optional preemption. It sits between the game/UI control logic, which issues requests, and the speaker pin.

## Interface
- `CLK_HZ`, 50000000, input clock frequency in Hz.
- `TICK_HZ`, 4, duration-unit rate in Hz. One unit lasts `TICK_DIV = CLK_HZ/TICK_HZ` clocks, using integer division.
- `NOTE_W`, 20, width of the note period in clocks.
- `DUR_W`, 5, width of a step duration in units.
- `PREEMPT`, 0. When 1, a `start` arriving during playback restarts the player with the new sound.

- `clk`, in, 1: system clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle request strobe.
- `sound`, in, 2: sound select, sampled with `start`.
- `mute`, in, 1: forces `tone` to 0. Sequencing continues.
- `busy`, out, 1: high while a sequence is playing.
- `done`, out, 1: one-cycle pulse when a sequence completes normally.
- `tone`, out, 1: square-wave audio output.
- `note`, out, NOTE_W: period of the current step. Holds 0 when idle.
- `step`, out, 2: index of the current step.

## Operation
- Sound ROM is internal and fixed. Each entry is (frequency, units). Period P = CLK_HZ/freq, integer division. A rest is encoded as P=1.
  - sound 0 "move": (459 Hz, 2).
  - sound 1 "switch": (980 Hz, 8).
  - sound 2 "enter": (700 Hz, 4), rest 1, (980 Hz, 4). This sequence has 3 steps.
  - sound 3 "silence": rest 2.
- FSM states are IDLE, PLAY and DONE.
  - IDLE: on `start`, latch `sound`, set `step`=0, load step 0, go to PLAY.
  - PLAY: the step counter counts units×TICK_DIV clocks.
    - At the end of a non-final step, load the next step with no gap and go to the next step.
    - At the end of the final step, go to DONE.
  - DONE: assert `done` for one cycle and return to IDLE. A `start` in DONE is accepted exactly as in IDLE.
- `start` during PLAY:
  - PREEMPT=0: ignored.
  - PREEMPT=1: the new sound loads on the next edge at step 0. There is no `done` for the aborted sound, and `busy` stays high.
- Tone generator:
  - A phase counter runs 0..P-1, wraps, and resets to 0 at every step load.
  - `tone` = 1 while phase < P/2 (floor), else 0.
  - For P<2, or when `mute`=1, `tone` = 0.
- Counter widths:
  - Step-duration counter: DUR_W + clog2(TICK_DIV) bits, with no overflow for any ROM entry.
  - Phase counter: NOTE_W bits.
- Outputs:
  - `busy` = (state==PLAY).
  - `note` = current step's P in PLAY, 0 otherwise.
  - `step` = 0 outside PLAY.

## Timing
- Reset is asynchronous and immediate, including mid-sequence. All outputs go to 0 (`busy`, `done`, `tone`, `note`, `step`) and the state goes to IDLE.
- `start` is sampled at edge N in IDLE or DONE. From cycle N+1, `busy`=1, `note` is valid and `tone`=1 (if P≥2 and not muted).
- Let L = Σunits×TICK_DIV over the sequence. `busy` is high for exactly L cycles (N+1..N+L). `done`=1 and `busy`=0 in cycle N+L+1.
- Each step boundary falls exactly units×TICK_DIV cycles after the previous step load. `step` and `note` change in the same cycle.
- `start` coincident with `done` is accepted: `busy` goes high at N+L+2.
- Under PREEMPT=1, `start` at edge M during PLAY restarts the sequence: step 0 and the new `note` appear in M+1, and the phase is reset.

## Test plan
Bench parameters for all scenarios: CLK_HZ=100000, TICK_HZ=100, so TICK_DIV=1000. Periods are 459 Hz → 217, 980 Hz → 102, 700 Hz → 142.

- Reset and idle: assert `reset` asynchronously. All outputs read 0 with no clock edge. Run 50 idle cycles and confirm no change.
- Sound 0 at cycle N:
  - `busy` is high for 2000 cycles and `done` is a single pulse at N+2001.
  - `tone` has period 217: 108 cycles high, 109 low.
  - `note`=217 throughout.
- Sound 2:
  - `step` reads 0 for cycles N+1..N+4000 (`note`=142), then 1 for N+4001..N+5000 (`note`=1, `tone`=0), then 2 for N+5001..N+9000 (`note`=102).
  - `done` pulses at N+9001.
- Handshake:
  - `start` during PLAY with PREEMPT=0 is ignored.
  - `start` in the `done` cycle launches a new sequence, with `busy` high at the next cycle.
  - `mute`=1 mid-sound forces `tone`=0 and leaves timing unchanged.
- PREEMPT=1: issue sound 1, then sound 0 500 cycles later.
  - `note` switches to 217 on the next cycle and `step`=0.
  - Exactly one `done` pulse, 2001 cycles after the second `start`.
- Reset mid-sequence during sound 2, step 1: all outputs return to 0 immediately. A `start` after reset release behaves as from a fresh reset.
